// File: rtl/mips_fetch_decode_pipe_pkg.sv
// Shared constants for the MIPS front end: default widths, NOP encoding,
// and helpers that derive field offsets and the PC increment from the widths.
package mips_pkg;

  localparam int DEF_INSTR_W    = 16;
  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_REG_ADDR_W = 3;
  localparam int DEF_OPC_W      = 4;
  localparam int DEF_RESET_PC   = 0;

  // The NOP is the all-zero word, so it is width-agnostic.
  localparam logic [DEF_INSTR_W-1:0] NOP_INSTR = '0;

  function automatic int pc_step(input int instr_w);
    return instr_w / 8;
  endfunction

  function automatic int rs_lsb(input int instr_w, input int opc_w, input int reg_w);
    return instr_w - opc_w - reg_w;
  endfunction

  function automatic int rt_lsb(input int instr_w, input int opc_w, input int reg_w);
    return instr_w - opc_w - 2 * reg_w;
  endfunction

endpackage

// File: rtl/mips_fetch_decode_pipe_if.sv
// Instruction-memory fetch bus: the front end drives the address, the memory
// answers with data plus a valid flag (valid low means a wait state).
interface mips_fetch_decode_pipe_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
);
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_valid;

  modport master (output imem_addr, input imem_rdata, input imem_valid);
  modport slave  (input imem_addr, output imem_rdata, output imem_valid);
endinterface

// File: rtl/mips_fetch_decode_pipe_hazard.sv
// Load-use detector: flags when the instruction in IF/ID reads the register
// that a load currently in ID/EX will write. Register 0 is hardwired and never stalls.
module mips_hazard_unit #(
  parameter int REG_ADDR_W = 3
) (
  input  logic                  i_ifid_valid,
  input  logic                  i_idex_mem_read,
  input  logic [REG_ADDR_W-1:0] i_idex_rt,
  input  logic [REG_ADDR_W-1:0] i_ifid_rs,
  input  logic [REG_ADDR_W-1:0] i_ifid_rt,
  output logic                  o_hazard
);

  logic w_reg_match;

  assign w_reg_match = (i_idex_rt == i_ifid_rs) || (i_idex_rt == i_ifid_rt);
  assign o_hazard    = i_ifid_valid && i_idex_mem_read && (i_idex_rt != '0) && w_reg_match;

endmodule

// File: rtl/mips_fetch_decode_pipe.sv
// MIPS front end: PC register, instruction fetch request and IF/ID register,
// with branch flush, downstream/load-use stall and memory wait-state bubbles.
module mips_fetch_decode_pipe
  import mips_pkg::*;
#(
  parameter int INSTR_W    = DEF_INSTR_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int OPC_W      = DEF_OPC_W,
  parameter int RESET_PC   = DEF_RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst,
  mips_fetch_decode_pipe_if.master imem,
  input  logic                  stall_i,
  input  logic                  branch_taken_i,
  input  logic [ADDR_W-1:0]     branch_target_i,
  input  logic                  idex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] idex_rt_i,
  output logic [INSTR_W-1:0]    ifid_instr,
  output logic [ADDR_W-1:0]     ifid_pc_plus,
  output logic                  ifid_valid,
  output logic [REG_ADDR_W-1:0] ifid_rs,
  output logic [REG_ADDR_W-1:0] ifid_rt,
  output logic                  hazard_stall_o,
  output logic                  id_bubble_o
);

  localparam int                RS_LSB   = rs_lsb(INSTR_W, OPC_W, REG_ADDR_W);
  localparam int                RT_LSB   = rt_lsb(INSTR_W, OPC_W, REG_ADDR_W);
  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(pc_step(INSTR_W));
  localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(RESET_PC);
  localparam logic [INSTR_W-1:0] NOP     = '0;

  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_ifid_instr;
  logic [ADDR_W-1:0]  r_ifid_pc_plus;
  logic               r_ifid_valid;
  logic [ADDR_W-1:0]  w_pc_plus;
  logic               w_hazard;

  // Natural ADDR_W-bit overflow gives the required wrap from the top address to 0.
  assign w_pc_plus      = r_pc + PC_STEP;
  assign imem.imem_addr = r_pc;

  assign ifid_instr   = r_ifid_instr;
  assign ifid_pc_plus = r_ifid_pc_plus;
  assign ifid_valid   = r_ifid_valid;
  assign ifid_rs      = r_ifid_instr[RS_LSB +: REG_ADDR_W];
  assign ifid_rt      = r_ifid_instr[RT_LSB +: REG_ADDR_W];

  mips_hazard_unit #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard (
    .i_ifid_valid    (r_ifid_valid),
    .i_idex_mem_read (idex_mem_read_i),
    .i_idex_rt       (idex_rt_i),
    .i_ifid_rs       (ifid_rs),
    .i_ifid_rt       (ifid_rt),
    .o_hazard        (w_hazard)
  );

  assign hazard_stall_o = w_hazard;
  assign id_bubble_o    = w_hazard || !r_ifid_valid;

  // A redirect beats any stall; a wait state only bubbles IF/ID while PC re-requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc           <= PC_RESET;
      r_ifid_instr   <= NOP;
      r_ifid_pc_plus <= '0;
      r_ifid_valid   <= 1'b0;
    end else if (branch_taken_i) begin
      r_pc         <= branch_target_i;
      r_ifid_instr <= NOP;
      r_ifid_valid <= 1'b0;
    end else if (stall_i || w_hazard) begin
      r_pc           <= r_pc;
      r_ifid_instr   <= r_ifid_instr;
      r_ifid_pc_plus <= r_ifid_pc_plus;
      r_ifid_valid   <= r_ifid_valid;
    end else if (!imem.imem_valid) begin
      r_ifid_instr <= NOP;
      r_ifid_valid <= 1'b0;
    end else begin
      r_pc           <= w_pc_plus;
      r_ifid_instr   <= imem.imem_rdata;
      r_ifid_pc_plus <= w_pc_plus;
      r_ifid_valid   <= 1'b1;
    end
  end

endmodule
